// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing blocks: LFSR constants, FSM states
// and a constant-evaluable ceil(log2) helper.
package sc_pkg;

    localparam int unsigned LFSR_W = 16;
    // Taps for x^16 + x^14 + x^13 + x^11 + 1 on a left-shifting register.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } sc_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// 16-bit Fibonacci LFSR used as a random select/number source by the SC blocks.
// Advances only when en is high so consumers can tie it to their beat valid.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (en) begin
            state <= {state[LFSR_W-2:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/sc_matvec_accum.sv
// Stochastic matrix-vector product: per-channel AND/XNOR products, multiplexed by an LFSR
// select (scaled dot product), and accumulated over a fixed window of result beats.
module sc_matvec_accum
    import sc_pkg::*;
#(
    parameter int unsigned       DIMENSION   = 8,
    parameter int unsigned       NUM_OUTPUTS = 4,
    parameter int unsigned       BIPOLAR     = 0,
    parameter int unsigned       WINDOW      = 256,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1,
    localparam int unsigned      SEL_W       = clog2(DIMENSION),
    localparam int unsigned      CNT_W       = clog2(WINDOW + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             in_valid,
    input  logic [DIMENSION-1:0]             data,
    input  logic [NUM_OUTPUTS*DIMENSION-1:0] weights,
    output logic [NUM_OUTPUTS-1:0]           result,
    output logic                             result_valid,
    output logic [NUM_OUTPUTS*CNT_W-1:0]     count,
    output logic                             busy,
    output logic                             done
);

    logic [LFSR_W-1:0]    lfsr_state;
    logic [DIMENSION-1:0] prod_q [NUM_OUTPUTS];
    logic [SEL_W-1:0]     sel_q;
    logic                 v1_q;
    logic                 v2_q;
    logic [NUM_OUTPUTS-1:0] result_q;

    sc_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (in_valid),
        .state (lfsr_state)
    );

    // Stage 1: products plus the pre-advance select, so both describe the same beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                sel_q <= lfsr_state[SEL_W-1:0];
                for (int k = 0; k < NUM_OUTPUTS; k++) begin
                    if (BIPOLAR != 0) begin
                        prod_q[k] <= ~(data ^ weights[k*DIMENSION +: DIMENSION]);
                    end else begin
                        prod_q[k] <= data & weights[k*DIMENSION +: DIMENSION];
                    end
                end
            end
        end
    end

    // Stage 2: scaled addition by random selection; result holds across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q     <= 1'b0;
            result_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                for (int k = 0; k < NUM_OUTPUTS; k++) begin
                    result_q[k] <= prod_q[k][sel_q];
                end
            end
        end
    end

    assign result       = result_q;
    assign result_valid = v2_q;

    sc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q [NUM_OUTPUTS];
    logic [CNT_W-1:0] cnt_d [NUM_OUTPUTS];
    logic [CNT_W-1:0] beat_q, beat_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    beat_d  = '0;
                    for (int k = 0; k < NUM_OUTPUTS; k++) begin
                        cnt_d[k] = '0;
                    end
                end
            end
            StRun: begin
                if (v2_q) begin
                    beat_d = beat_q + 1'b1;
                    for (int k = 0; k < NUM_OUTPUTS; k++) begin
                        cnt_d[k] = cnt_q[k] + CNT_W'(result_q[k]);
                    end
                    // The beat that completes the window ends RUN on this same edge.
                    if (beat_q == CNT_W'(WINDOW - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            beat_q  <= '0;
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_count
        assign count[k*CNT_W +: CNT_W] = cnt_q[k];
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_sc_matvec_accum.sv
// Randomized bench for sc_matvec_accum: a unipolar and a bipolar instance share stimulus
// and are compared every cycle against a beat-queue reference model.
module tb_sc_matvec_accum;

    localparam int D  = 4;
    localparam int NO = 4;
    localparam int WIN = 256;
    localparam int CW = 9;
    localparam int NS = 1400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic [D-1:0] data = '0;
    logic [NO*D-1:0] weights = '0;

    logic [NO-1:0] res_u, res_b;
    logic rv_u, rv_b, busy_u, busy_b, done_u, done_b;
    logic [NO*CW-1:0] cnt_u, cnt_b;

    always #5 clk = ~clk;

    sc_matvec_accum #(
        .DIMENSION(D), .NUM_OUTPUTS(NO), .BIPOLAR(0), .WINDOW(WIN), .LFSR_SEED(16'hACE1)
    ) u_uni (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .data(data),
        .weights(weights), .result(res_u), .result_valid(rv_u), .count(cnt_u),
        .busy(busy_u), .done(done_u)
    );

    sc_matvec_accum #(
        .DIMENSION(D), .NUM_OUTPUTS(NO), .BIPOLAR(1), .WINDOW(WIN), .LFSR_SEED(16'hACE1)
    ) u_bip (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .data(data),
        .weights(weights), .result(res_b), .result_valid(rv_b), .count(cnt_b),
        .busy(busy_b), .done(done_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: beats are scored at acceptance and queued until they emerge.
    typedef struct {
        int            due;
        logic [NO-1:0] ru;
        logic [NO-1:0] rb;
    } beat_t;

    beat_t         q[$];
    int            cyc = 0;
    logic [15:0]   m_lfsr;
    logic          m_rv;
    logic [NO-1:0] m_res_u, m_res_b;
    int            m_cnt_u[NO];
    int            m_cnt_b[NO];
    int            m_state;   // 0 idle, 1 run, 2 done
    int            m_beats;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic model_edge();
        beat_t b;
        int sel;
        cyc++;
        if (rst) begin
            m_lfsr = 16'hACE1;
            q.delete();
            m_rv = 1'b0;
            m_res_u = '0;
            m_res_b = '0;
            m_state = 0;
            m_beats = 0;
            for (int k = 0; k < NO; k++) begin
                m_cnt_u[k] = 0;
                m_cnt_b[k] = 0;
            end
            return;
        end
        if (m_state == 0) begin
            if (start) begin
                m_state = 1;
                m_beats = 0;
                for (int k = 0; k < NO; k++) begin
                    m_cnt_u[k] = 0;
                    m_cnt_b[k] = 0;
                end
            end
        end else if (m_state == 1) begin
            if (m_rv) begin
                for (int k = 0; k < NO; k++) begin
                    m_cnt_u[k] += int'(m_res_u[k]);
                    m_cnt_b[k] += int'(m_res_b[k]);
                end
                m_beats++;
                if (m_beats == WIN) m_state = 2;
            end
        end else begin
            m_state = 0;
        end
        if (in_valid) begin
            sel = int'(m_lfsr[1:0]);
            b.due = cyc + 1;
            for (int k = 0; k < NO; k++) begin
                b.ru[k] = data[sel] & weights[k*D + sel];
                b.rb[k] = ~(data[sel] ^ weights[k*D + sel]);
            end
            q.push_back(b);
            m_lfsr = lfsr_next(m_lfsr);
        end
        m_rv = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            m_rv = 1'b1;
            m_res_u = q[0].ru;
            m_res_b = q[0].rb;
            void'(q.pop_front());
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        chk("lfsr_u", u_uni.lfsr_state, m_lfsr);
        chk("result_valid_u", rv_u, m_rv);
        chk("result_valid_b", rv_b, m_rv);
        chk("result_u", res_u, m_res_u);
        chk("result_b", res_b, m_res_b);
        chk("busy_u", busy_u, m_state == 1);
        chk("busy_b", busy_b, m_state == 1);
        chk("done_u", done_u, m_state == 2);
        chk("done_b", done_b, m_state == 2);
        for (int k = 0; k < NO; k++) begin
            chk($sformatf("count_u[%0d]", k), cnt_u[k*CW +: CW], m_cnt_u[k]);
            chk($sformatf("count_b[%0d]", k), cnt_b[k*CW +: CW], m_cnt_b[k]);
        end
    endtask

    logic          sv_valid[NS];
    logic [D-1:0]  sv_data[NS];
    logic [NO*D-1:0] sv_w[NS];

    task automatic fill(input int vmode, input logic [D-1:0] d, input logic [NO*D-1:0] w);
        for (int i = 0; i < NS; i++) begin
            sv_valid[i] = (vmode == 0) ? 1'b1 : (vmode == 1) ? (i % 2 == 0)
                                                : ($urandom_range(3) != 0);
            sv_data[i] = (vmode == 2) ? D'($urandom) : d;
            sv_w[i] = (vmode == 2) ? (NO*D)'($urandom) : w;
        end
    endtask

    // Reset, start a window, replay the stored stimulus; optionally reset after abort_beats.
    task automatic play(input int abort_beats, output int n_done, output int dur);
        int t0;
        bit fin;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        step();
        rst = 1'b0;
        n_done = 0;
        dur = -1;
        fin = 1'b0;
        t0 = cyc + 1;
        for (int i = 0; i < NS && !fin; i++) begin
            start = (i == 0);
            in_valid = sv_valid[i];
            data = sv_data[i];
            weights = sv_w[i];
            step();
            if (done_u) begin
                n_done++;
                dur = cyc - t0;
            end
            if (abort_beats > 0 && m_state == 1 && m_beats == abort_beats) begin
                rst = 1'b1; start = 1'b0;
                step();
                rst = 1'b0; in_valid = 1'b0;
                for (int j = 0; j < 6; j++) begin
                    step();
                    if (done_u) n_done++;
                end
                fin = 1'b1;
            end else if (n_done > 0 && !done_u) begin
                fin = 1'b1;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    int nd, dur, golden;
    int ref_u[NO];
    int ref_b[NO];
    logic [15:0] s;

    initial begin
        rst = 1'b1;
        step();
        chk("reset_busy", busy_u, 0);
        chk("reset_done", done_u, 0);
        chk("reset_count", cnt_u, 0);
        chk("reset_lfsr", u_uni.lfsr_state, 16'hACE1);

        // All-ones inputs: every channel counts the full window in both polarities.
        fill(0, 4'b1111, 16'hFFFF);
        play(0, nd, dur);
        chk("ones_done_pulses", nd, 1);
        chk("ones_duration", dur, 257);
        chk("ones_busy_after", busy_u, 0);
        for (int k = 0; k < NO; k++) begin
            chk($sformatf("ones_u[%0d]", k), cnt_u[k*CW +: CW], 256);
            chk($sformatf("ones_b[%0d]", k), cnt_b[k*CW +: CW], 256);
        end

        fill(0, 4'b1111, {4'b0101, 4'b1010, 4'b1111, 4'b0000});
        play(0, nd, dur);
        chk("w0_u", cnt_u[0 +: CW], 0);
        chk("w1_u", cnt_u[CW +: CW], 256);
        chk("w0_b", cnt_b[0 +: CW], 0);
        chk("w1_b", cnt_b[CW +: CW], 256);

        fill(0, 4'b1111, 16'h0000);
        play(0, nd, dur);
        for (int k = 0; k < NO; k++) begin
            chk($sformatf("zero_w_b[%0d]", k), cnt_b[k*CW +: CW], 0);
        end

        // data=0011: hits equal the number of selects landing on bits 0/1.
        golden = 0;
        s = 16'hACE1;
        for (int i = 0; i < WIN; i++) begin
            if (s[1:0] < 2'd2) golden++;
            s = lfsr_next(s);
        end
        fill(0, 4'b0011, 16'hFFFF);
        play(0, nd, dur);
        for (int k = 0; k < NO; k++) begin
            ref_u[k] = int'(cnt_u[k*CW +: CW]);
            chk($sformatf("half_golden_u[%0d]", k), ref_u[k], golden);
        end

        fill(1, 4'b0011, 16'hFFFF);
        play(0, nd, dur);
        chk("toggle_done_pulses", nd, 1);
        chk("toggle_duration_ok", (dur >= 505 && dur <= 520) ? 1 : 0, 1);
        for (int k = 0; k < NO; k++) begin
            chk($sformatf("toggle_same_u[%0d]", k), cnt_u[k*CW +: CW], ref_u[k]);
        end

        // Random beats: full run, aborted run, then rerun must reproduce the first.
        fill(2, '0, '0);
        play(0, nd, dur);
        chk("rand_done_pulses", nd, 1);
        for (int k = 0; k < NO; k++) begin
            ref_u[k] = int'(cnt_u[k*CW +: CW]);
            ref_b[k] = int'(cnt_b[k*CW +: CW]);
        end
        play(100, nd, dur);
        chk("abort_no_done", nd, 0);
        chk("abort_busy", busy_u, 0);
        chk("abort_count", cnt_u, 0);
        play(0, nd, dur);
        chk("rerun_done_pulses", nd, 1);
        for (int k = 0; k < NO; k++) begin
            chk($sformatf("rerun_u[%0d]", k), cnt_u[k*CW +: CW], ref_u[k]);
            chk($sformatf("rerun_b[%0d]", k), cnt_b[k*CW +: CW], ref_b[k]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
